// File: rtl/damage_if.sv
// Hit/heal request bus between game-logic requesters and the damage scheduler.
interface damage_if #(
  parameter int N_SRC = 4
);
  logic [N_SRC-1:0]   hit_req;
  logic [2*N_SRC-1:0] hit_dmg;
  logic               heal_req;
  logic [N_SRC-1:0]   hit_ack;
  logic [3:0]         health;
  logic               invuln;
  logic               flash;
  logic               die;

  modport master (
    output hit_req, hit_dmg, heal_req,
    input  hit_ack, health, invuln, flash, die
  );

  modport slave (
    input  hit_req, hit_dmg, heal_req,
    output hit_ack, health, invuln, flash, die
  );
endinterface

// File: rtl/damage_scheduler.sv
// Health/damage controller: round-robin hit arbitration, tick-timed invulnerability window,
// heal handling and an absorbing DEAD state.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_ALIVE  | accepts one hit per grant (round-robin), heals allowed
// ST_INVULN | all hits absorbed without damage, counts down game ticks
// ST_DEAD   | health 0, absorbs all hits, ignores heals until reset
module damage_scheduler #(
  parameter int N_SRC        = 4,
  parameter int HP_MAX       = 10,
  parameter int TICK_DIV     = 1000000,
  parameter int INVULN_TICKS = 50
) (
  input logic     clk,
  input logic     rst,
  damage_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = $clog2(INVULN_TICKS + 1);
  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  localparam logic [3:0] HP_TOP = 4'(HP_MAX);

  localparam logic [1:0] ST_ALIVE  = 2'd0;
  localparam logic [1:0] ST_INVULN = 2'd1;
  localparam logic [1:0] ST_DEAD   = 2'd2;

  logic [1:0]       state;
  logic [PW-1:0]    pre_cnt;
  logic             tick;
  logic [IW-1:0]    inv_cnt;
  logic [SW-1:0]    ptr;
  logic [3:0]       health;
  logic [N_SRC-1:0] ack;
  logic             flash_q;

  logic             grant_valid;
  logic [SW-1:0]    grant_idx;
  logic [SW-1:0]    ptr_next;
  logic [1:0]       dmg_sel;
  logic [3:0]       dmg;
  logic [3:0]       hp_hit;
  logic [3:0]       hp_heal;

  assign tick = (pre_cnt == PW'(TICK_DIV - 1));

  // Walk offsets from the far end down so the lowest offset from ptr wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (bus.hit_req[(int'(ptr) + k) % N_SRC]) begin
        grant_valid = 1'b1;
        grant_idx   = SW'((int'(ptr) + k) % N_SRC);
      end
    end
  end

  always_comb begin
    ptr_next = (grant_idx == SW'(N_SRC - 1)) ? '0 : grant_idx + SW'(1);
    dmg_sel  = bus.hit_dmg[2*int'(grant_idx) +: 2];
    dmg      = (dmg_sel == 2'd0) ? 4'd1 : {2'b00, dmg_sel};
    hp_hit   = (health > dmg) ? health - dmg : 4'd0;
    hp_heal  = (health >= HP_TOP) ? HP_TOP : health + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_ALIVE;
      pre_cnt <= '0;
      inv_cnt <= '0;
      ptr     <= '0;
      health  <= HP_TOP;
      ack     <= '0;
      flash_q <= 1'b0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
      ack     <= '0;
      case (state)
        ST_ALIVE: begin
          if (grant_valid) begin
            health <= hp_hit;
            ack    <= N_SRC'(1) << grant_idx;
            ptr    <= ptr_next;
            if (hp_hit == 4'd0) begin
              state <= ST_DEAD;
            end else begin
              state   <= ST_INVULN;
              inv_cnt <= IW'(INVULN_TICKS);
            end
          end else if (bus.heal_req) begin
            health <= hp_heal;
          end
        end
        ST_INVULN: begin
          ack <= bus.hit_req;
          if (bus.heal_req) health <= hp_heal;
          if (tick) begin
            if (inv_cnt == IW'(1)) begin
              state   <= ST_ALIVE;
              inv_cnt <= '0;
              flash_q <= 1'b0;
            end else begin
              inv_cnt <= inv_cnt - IW'(1);
              flash_q <= ~flash_q;
            end
          end
        end
        ST_DEAD: begin
          ack     <= bus.hit_req;
          health  <= 4'd0;
          flash_q <= 1'b0;
        end
        default: begin
          state   <= ST_ALIVE;
          flash_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hit_ack = ack;
  assign bus.health  = health;
  assign bus.invuln  = (state == ST_INVULN);
  assign bus.die     = (state == ST_DEAD);
  assign bus.flash   = flash_q;

endmodule

// File: tb/tb_damage_scheduler.sv
// Directed vector bench for damage_scheduler with a 4-cycle game tick and a 2-tick
// invulnerability window; rows hold inputs for 'rep' edges and check outputs after the last.
module tb_damage_scheduler;

  logic clk;
  logic rst;

  damage_if #(.N_SRC(4)) bus ();

  damage_scheduler #(
    .N_SRC(4),
    .HP_MAX(10),
    .TICK_DIV(4),
    .INVULN_TICKS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [7:0] dmg;
    logic       heal;
    int         rep;
    logic [3:0] ack;
    logic [3:0] hp;
    logic       inv;
    logic       die;
    logic       fl;
  } vec_t;

  vec_t vecs[$];
  int   tests;
  int   fails;

  task automatic add(input logic r, input logic [3:0] req, input logic [7:0] dmg,
                     input logic heal, input int rep, input logic [3:0] ack,
                     input logic [3:0] hp, input logic inv, input logic die, input logic fl);
    vec_t v;
    v.rst = r; v.req = req; v.dmg = dmg; v.heal = heal; v.rep = rep;
    v.ack = ack; v.hp = hp; v.inv = inv; v.die = die; v.fl = fl;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [3:0] req, input logic [7:0] dmg,
                       input logic heal);
    rst          = r;
    bus.hit_req  = req;
    bus.hit_dmg  = dmg;
    bus.heal_req = heal;
  endtask

  initial begin
    int n;
    tests = 0;
    fails = 0;
    drive(1'b1, 4'b0, 8'h00, 1'b0);

    // Reset at edge 0 leaves the prescaler at 0, so ticks land on edges 4, 8, 12, ...
    //   rst req      dmg    heal rep  ack      hp inv die fl
    add(1, 4'b0000, 8'h00, 0, 1, 4'b0000, 10, 0, 0, 0);
    add(0, 4'b1010, 8'h00, 0, 1, 4'b0010,  9, 1, 0, 0);  // ptr 0 -> src1 wins
    add(0, 4'b1000, 8'h00, 0, 1, 4'b1000,  9, 1, 0, 0);  // src3 absorbed
    add(0, 4'b0000, 8'h00, 0, 1, 4'b0000,  9, 1, 0, 0);
    add(0, 4'b0000, 8'h00, 0, 1, 4'b0000,  9, 1, 0, 1);  // 1st tick: flash on
    add(0, 4'b0000, 8'h00, 1, 1, 4'b0000, 10, 1, 0, 1);  // heal in INVULN
    add(0, 4'b0000, 8'h00, 1, 1, 4'b0000, 10, 1, 0, 1);  // heal saturates
    add(0, 4'b0000, 8'h00, 0, 1, 4'b0000, 10, 1, 0, 1);
    add(0, 4'b0000, 8'h00, 0, 1, 4'b0000, 10, 0, 0, 0);  // 2nd tick: ALIVE
    add(0, 4'b0000, 8'h00, 1, 1, 4'b0000, 10, 0, 0, 0);  // heal at max in ALIVE
    add(0, 4'b0001, 8'h02, 0, 1, 4'b0001,  8, 1, 0, 0);  // ptr 2 wraps to src0
    add(0, 4'b0000, 8'h00, 0, 1, 4'b0000,  8, 1, 0, 0);
    add(0, 4'b0000, 8'h00, 0, 1, 4'b0000,  8, 1, 0, 1);
    add(1, 4'b0001, 8'h02, 0, 1, 4'b0000, 10, 0, 0, 0);  // rst mid-INVULN, no ack
    add(0, 4'b0001, 8'h02, 0, 1, 4'b0001,  8, 1, 0, 0);  // held bit is a new request
    add(0, 4'b0000, 8'h00, 0, 2, 4'b0000,  8, 1, 0, 0);
    add(0, 4'b0000, 8'h00, 0, 1, 4'b0000,  8, 1, 0, 1);
    add(0, 4'b0000, 8'h00, 0, 4, 4'b0000,  8, 0, 0, 0);
    add(0, 4'b0001, 8'h01, 1, 1, 4'b0001,  7, 1, 0, 0);  // grant beats heal
    add(0, 4'b0000, 8'h00, 0, 3, 4'b0000,  7, 1, 0, 1);
    add(0, 4'b0000, 8'h00, 0, 4, 4'b0000,  7, 0, 0, 0);
    add(0, 4'b0010, 8'h0C, 0, 1, 4'b0010,  4, 1, 0, 0);  // src1 dmg 3
    add(0, 4'b0000, 8'h00, 0, 6, 4'b0000,  4, 1, 0, 1);
    add(0, 4'b0000, 8'h00, 0, 1, 4'b0000,  4, 0, 0, 0);
    add(0, 4'b0100, 8'h20, 0, 1, 4'b0100,  2, 1, 0, 0);  // src2 dmg 2
    add(0, 4'b0000, 8'h00, 0, 6, 4'b0000,  2, 1, 0, 1);
    add(0, 4'b0000, 8'h00, 0, 1, 4'b0000,  2, 0, 0, 0);
    add(0, 4'b1000, 8'hC0, 0, 1, 4'b1000,  0, 0, 1, 0);  // 2 - 3 saturates to 0
    add(0, 4'b0000, 8'h00, 0, 1, 4'b0000,  0, 0, 1, 0);
    add(0, 4'b0100, 8'h00, 0, 1, 4'b0100,  0, 0, 1, 0);  // DEAD absorbs
    add(0, 4'b0000, 8'h00, 1, 1, 4'b0000,  0, 0, 1, 0);  // heal ignored
    add(0, 4'b0000, 8'h00, 0, 4, 4'b0000,  0, 0, 1, 0);
    add(1, 4'b0010, 8'h00, 0, 1, 4'b0000, 10, 0, 0, 0);  // rst out of DEAD
    add(0, 4'b0000, 8'h00, 1, 1, 4'b0000, 10, 0, 0, 0);
    add(0, 4'b1111, 8'h00, 0, 1, 4'b0001,  9, 1, 0, 0);  // one grant only
    add(0, 4'b1110, 8'h00, 0, 1, 4'b1110,  9, 1, 0, 0);  // rest absorbed
    add(0, 4'b0000, 8'h00, 0, 1, 4'b0000,  9, 1, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].dmg, vecs[i].heal);
      repeat (vecs[i].rep) @(posedge clk);
      #1;
      tests++;
      if (bus.hit_ack !== vecs[i].ack || bus.health !== vecs[i].hp ||
          bus.invuln !== vecs[i].inv || bus.die !== vecs[i].die ||
          bus.flash !== vecs[i].fl) begin
        fails++;
        $display("FAIL vec%0d: got ack=%b hp=%0d inv=%b die=%b fl=%b, want ack=%b hp=%0d inv=%b die=%b fl=%b",
                 i, bus.hit_ack, bus.health, bus.invuln, bus.die, bus.flash,
                 vecs[i].ack, vecs[i].hp, vecs[i].inv, vecs[i].die, vecs[i].fl);
      end
    end

    // Window exit: the last row was the first tick, the next tick is 4 edges away.
    drive(1'b0, 4'b0000, 8'h00, 1'b0);
    n = 0;
    while (bus.invuln === 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests++;
    if (n != 4) begin
      fails++;
      $display("FAIL invuln_exit: left INVULN after %0d edges, want 4", n);
    end
    tests++;
    if (bus.flash !== 1'b0 || bus.health !== 4'd9 || bus.hit_ack !== 4'b0000) begin
      fails++;
      $display("FAIL after_exit: got fl=%b hp=%0d ack=%b, want fl=0 hp=9 ack=0000",
               bus.flash, bus.health, bus.hit_ack);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
